// File: rtl/mcpu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_R_WB     = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_EXEC_I   = 4'd11,
        S_I_WB     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Fault codes
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // States that sit on the memory port waiting for mem_ready
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Unified memory port between the sequencer and instruction/data memory.
// Handshake: a request (mem_read or mem_write, with i_or_d selecting the
// address) is held stable from the cycle it rises until the cycle in which
// mem_ready is sampled high; that cycle completes the transfer. mem_read and
// mem_write are never high together.
interface multicycle_control_fsm_if;
    logic mem_read;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;

    modport master (output mem_read, output mem_write, output i_or_d, input mem_ready);
    modport slave  (input mem_read, input mem_write, input i_or_d, output mem_ready);
endinterface

// File: rtl/mcpu_alu_decoder.sv
// Combinational funct decoder: ALU operation plus a legal-funct flag.
module mcpu_alu_decoder
    import mcpu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       legal
);

    // Map the R-type funct field onto an ALU operation
    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared datapath,
// with retired-instruction counting and traps on illegal ops or memory timeout.
module multicycle_control_fsm
    import mcpu_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  halt,
    multicycle_control_fsm_if.master mem,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [3:0]            alu_control,
    output logic [1:0]            pc_source,
    output logic [CNT_W-1:0]      retired_count,
    output logic [1:0]            fault,
    output logic [3:0]            state_dbg
);

    // Counter holds 0..WAIT_LIMIT-1; the cycle that would reach WAIT_LIMIT traps instead
    localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (WAIT_LIMIT == 0) ? '0 : WAIT_W'(WAIT_LIMIT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        fault_q, fault_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [3:0]        dec_alu;
    logic              dec_legal;
    logic              retire;

    mcpu_alu_decoder u_alu_dec (
        .funct       (funct),
        .alu_control (dec_alu),
        .legal       (dec_legal)
    );

    // State, retire counter, fault code and memory wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fault_q <= FAULT_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    // Next state, retirement and timeout detection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        wait_d  = '0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:     if (!halt) state_d = S_FETCH;
            S_FETCH:    if (mem.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = dec_legal ? S_EXEC_R : S_TRAP;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_EXEC_I;
                    default:      state_d = S_TRAP;
                endcase
                if (state_d == S_TRAP) fault_d = FAULT_ILLEGAL;
            end
            S_EXEC_R:   state_d = S_R_WB;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem.mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem.mem_ready) retire = 1'b1;
            S_EXEC_I:   state_d = S_I_WB;
            S_R_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_I_WB: retire = 1'b1;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
        if (retire) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = halt ? S_IDLE : S_FETCH;
        end
        if (is_mem_state(state_q) && !mem.mem_ready && (WAIT_LIMIT != 0)) begin
            if (wait_q == WAIT_LAST) begin
                state_d = S_TRAP;
                fault_d = FAULT_TIMEOUT;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end
    end

    // Moore control decode; pc_write/ir_write also follow mem_ready or zero
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.i_or_d    = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_control   = ALU_AND;
        pc_source     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                mem.mem_read = 1'b1;
                alu_src_b    = SRCB_FOUR;
                alu_control  = ALU_ADD;
                ir_write     = mem.mem_ready;
                pc_write     = mem.mem_ready;
            end
            S_DECODE: begin
                alu_src_b   = SRCB_IMM_SH;
                alu_control = ALU_ADD;
            end
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_control = dec_alu;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
            end
            S_MEM_RD: begin
                mem.mem_read = 1'b1;
                mem.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                mem.mem_write = 1'b1;
                mem.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_source   = PCSRC_ALUOUT;
                pc_write    = zero;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
            end
            S_I_WB:     reg_write = 1'b1;
            default: ;
        endcase
    end

    assign retired_count = cnt_q;
    assign fault         = fault_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction phase-plan model,
// directed scenarios with literal expectations, then randomized instruction mix.
module tb_multicycle_control_fsm;
    import mcpu_pkg::*;

    localparam int LIMIT = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        halt = 1'b1;
    logic        pc_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_source, fault;
    logic [3:0]  alu_control, state_dbg;
    logic [31:0] retired_count;

    multicycle_control_fsm_if mem_if ();

    multicycle_control_fsm #(.CNT_W(32), .WAIT_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .halt          (halt),
        .mem           (mem_if),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .pc_source     (pc_source),
        .retired_count (retired_count),
        .fault         (fault),
        .state_dbg     (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    logic [16:0] dut_ctrl;
    assign dut_ctrl = {pc_write, mem_if.i_or_d, ir_write, mem_if.mem_read, mem_if.mem_write,
                       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control, pc_source};

    int vectors = 0;
    int miscompares = 0;

    // Reference model: current phase plus the list of phases still to run
    state_t      m_ph;
    state_t      plan_q[$];
    int          m_wait;
    logic [31:0] m_cnt;
    logic [1:0]  m_fault;

    // Observation trackers used by literal checks
    logic [3:0]  seen_q[$];
    logic [3:0]  exp_q[$];
    int          rw_pulses, mrd_cycles, mw_cycles, busy_cycles, trap_mr;
    logic [3:0]  rw_state;
    logic        br_pw;
    logic [1:0]  br_ps;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic bit legal_fn(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    // Expected controls for a phase, given the live inputs
    function automatic logic [16:0] exp_ctrl(input state_t p, input logic [5:0] f,
                                             input logic z, input logic r);
        logic pw, iod, irw, mr, mw, rd, m2r, rw, sa;
        logic [1:0] sb, ps;
        logic [3:0] alu;
        {pw, iod, irw, mr, mw, rd, m2r, rw, sa} = '0;
        sb = 2'b00; ps = 2'b00; alu = 4'b0000;
        case (p)
            S_FETCH:    begin mr = 1; sb = 2'b01; alu = 4'b0010; irw = r; pw = r; end
            S_DECODE:   begin sb = 2'b11; alu = 4'b0010; end
            S_EXEC_R:   begin sa = 1; alu = alu_of(f); end
            S_R_WB:     begin rd = 1; rw = 1; end
            S_MEM_ADDR: begin sa = 1; sb = 2'b10; alu = 4'b0010; end
            S_MEM_RD:   begin mr = 1; iod = 1; end
            S_MEM_WB:   begin m2r = 1; rw = 1; end
            S_MEM_WR:   begin mw = 1; iod = 1; end
            S_BRANCH:   begin sa = 1; alu = 4'b0110; ps = 2'b01; pw = z; end
            S_JUMP:     begin ps = 2'b10; pw = 1; end
            S_EXEC_I:   begin sa = 1; sb = 2'b10; alu = 4'b0010; end
            S_I_WB:     begin rw = 1; end
            default: ;
        endcase
        return {pw, iod, irw, mr, mw, rd, m2r, rw, sa, sb, alu, ps};
    endfunction

    task automatic build_plan(input logic [5:0] op, input logic [5:0] f);
        plan_q.delete();
        plan_q.push_back(S_DECODE);
        case (op)
            6'b000000: if (legal_fn(f)) begin plan_q.push_back(S_EXEC_R); plan_q.push_back(S_R_WB); end
                       else plan_q.push_back(S_TRAP);
            6'b100011: begin plan_q.push_back(S_MEM_ADDR); plan_q.push_back(S_MEM_RD); plan_q.push_back(S_MEM_WB); end
            6'b101011: begin plan_q.push_back(S_MEM_ADDR); plan_q.push_back(S_MEM_WR); end
            6'b000100: plan_q.push_back(S_BRANCH);
            6'b000010: plan_q.push_back(S_JUMP);
            6'b001000: begin plan_q.push_back(S_EXEC_I); plan_q.push_back(S_I_WB); end
            default:   plan_q.push_back(S_TRAP);
        endcase
    endtask

    task automatic model_reset();
        m_ph = S_IDLE; plan_q.delete(); m_wait = 0; m_cnt = '0; m_fault = 2'b00;
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_step();
        if (!reset_n) begin model_reset(); return; end
        if (m_ph == S_TRAP) return;
        if (m_ph == S_IDLE) begin
            if (!halt) m_ph = S_FETCH;
            return;
        end
        if ((m_ph inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !mem_if.mem_ready) begin
            m_wait++;
            if (m_wait == LIMIT) begin m_ph = S_TRAP; m_fault = 2'b10; plan_q.delete(); end
            return;
        end
        m_wait = 0;
        if (m_ph == S_FETCH) build_plan(opcode, funct);
        if (plan_q.size() == 0) begin
            m_cnt++;
            m_ph = halt ? S_IDLE : S_FETCH;
        end else begin
            m_ph = plan_q.pop_front();
            if (m_ph == S_TRAP) m_fault = 2'b01;
        end
    endtask

    task automatic clear_trk();
        seen_q.delete();
        rw_pulses = 0; mrd_cycles = 0; mw_cycles = 0; busy_cycles = 0; trap_mr = 0;
        rw_state = '0; br_pw = 1'bx; br_ps = 2'bxx;
    endtask

    // Compare every DUT output against the model and record observations
    task automatic compare_now();
        check("ctrl", dut_ctrl, exp_ctrl(m_ph, funct, zero, mem_if.mem_ready));
        check("state", state_dbg, m_ph);
        check("retired_count", retired_count, m_cnt);
        check("fault", fault, m_fault);
        seen_q.push_back(state_dbg);
        if (reg_write) begin rw_pulses++; rw_state = state_dbg; end
        if (mem_if.mem_read && mem_if.i_or_d) mrd_cycles++;
        if (mem_if.mem_write) mw_cycles++;
        if (state_dbg != S_IDLE) busy_cycles++;
        if (state_dbg == S_BRANCH) begin br_pw = pc_write; br_ps = pc_source; end
        if (state_dbg == S_TRAP && mem_if.mem_read) trap_mr++;
    endtask

    // One clock cycle: drive inputs just after the edge, check, advance model
    task automatic step(input logic r, input logic h, input logic z);
        mem_if.mem_ready = r; halt = h; zero = z;
        #1;
        compare_now();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n, input logic r, input logic h, input logic z);
        for (int i = 0; i < n; i++) step(r, h, z);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; mem_if.mem_ready = 1'b0; halt = 1'b1; zero = 1'b0;
        model_reset();
        #1;
        compare_now();
        @(posedge clk); #1;
        compare_now();
        reset_n = 1'b1;
    endtask

    task automatic pick_random();
        logic [5:0] fns [5];
        int r;
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        r = $urandom_range(0, 29);
        if (r < 10)      begin opcode = 6'b000000; funct = fns[r % 5]; end
        else if (r < 14) begin opcode = 6'b100011; funct = 6'($urandom); end
        else if (r < 18) begin opcode = 6'b101011; funct = 6'($urandom); end
        else if (r < 21) begin opcode = 6'b000100; funct = 6'($urandom); end
        else if (r < 24) begin opcode = 6'b000010; funct = 6'($urandom); end
        else if (r < 28) begin opcode = 6'b001000; funct = 6'($urandom); end
        else if (r == 28) begin opcode = 6'b111111; funct = 6'b100000; end
        else             begin opcode = 6'b000000; funct = 6'b000000; end
    endtask

    initial begin
        mem_if.mem_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();
        check("reset_count", retired_count, 0);
        check("reset_fault", fault, 0);

        // add, zero wait states
        clear_trk();
        opcode = 6'b000000; funct = 6'b100000;
        step(1, 0, 0);
        steps(4, 1, 1, 0);
        exp_q = '{4'(S_IDLE), 4'(S_FETCH), 4'(S_DECODE), 4'(S_EXEC_R), 4'(S_R_WB)};
        check("add_seq_len", seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) check("add_seq", seen_q[i], exp_q[i]);
        check("add_rw_pulses", rw_pulses, 1);
        check("add_count", retired_count, 1);
        check("add_idle", state_dbg, S_IDLE);

        // lw with 3 stall cycles in MEM_RD
        clear_trk();
        opcode = 6'b100011;
        step(1, 0, 0);
        steps(3, 1, 1, 0);
        steps(3, 0, 1, 0);
        steps(2, 1, 1, 0);
        check("lw_busy_cycles", busy_cycles, 8);
        check("lw_mem_rd_cycles", mrd_cycles, 4);
        check("lw_rw_pulses", rw_pulses, 1);
        check("lw_rw_state", rw_state, S_MEM_WB);
        check("lw_count", retired_count, 2);

        // beq taken / not taken
        clear_trk();
        opcode = 6'b000100;
        step(1, 0, 0); steps(2, 1, 1, 0); step(1, 1, 1);
        check("beq_z1_pc_write", br_pw, 1);
        check("beq_z1_pc_source", br_ps, 2'b01);
        clear_trk();
        step(1, 0, 0); steps(2, 1, 1, 0); step(1, 1, 0);
        check("beq_z0_pc_write", br_pw, 0);
        check("beq_count", retired_count, 4);

        // illegal opcode
        clear_trk();
        opcode = 6'b111111;
        step(1, 0, 0); steps(2, 1, 0, 0); steps(6, 1, 0, 0);
        check("ill_op_state", state_dbg, S_TRAP);
        check("ill_op_fault", fault, 2'b01);
        check("ill_op_no_read", trap_mr, 0);
        check("ill_op_count_held", retired_count, 4);
        do_reset();
        check("post_trap_fault", fault, 0);

        // illegal R-type funct
        opcode = 6'b000000; funct = 6'b000000;
        step(1, 0, 0); steps(5, 1, 0, 0);
        check("ill_fn_fault", fault, 2'b01);
        check("ill_fn_state", state_dbg, S_TRAP);
        do_reset();

        // fetch timeout after 16 not-ready cycles
        funct = 6'b100000;
        step(1, 0, 0); steps(16, 0, 1, 0);
        check("tmo_state", state_dbg, S_TRAP);
        check("tmo_fault", fault, 2'b10);
        do_reset();

        // 15 not-ready cycles then ready: normal completion
        step(1, 0, 0); steps(15, 0, 1, 0);
        check("stall15_state", state_dbg, S_FETCH);
        step(1, 1, 0);
        check("stall15_decode", state_dbg, S_DECODE);
        steps(3, 1, 1, 0);
        check("stall15_count", retired_count, 1);
        do_reset();

        // halt raised mid-sw: the store still completes, then idle
        clear_trk();
        opcode = 6'b101011;
        step(1, 0, 0); step(1, 0, 0); steps(2, 1, 1, 0); steps(2, 0, 1, 0); step(1, 1, 0);
        check("sw_mem_write_cycles", mw_cycles, 3);
        check("sw_halt_idle", state_dbg, S_IDLE);
        check("sw_count", retired_count, 1);

        // async reset while in MEM_WR
        step(1, 0, 0); steps(3, 1, 0, 0);
        mem_if.mem_ready = 1'b0;
        check("pre_rst_mem_write", mem_if.mem_write, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_ctrl", dut_ctrl, 0);
        check("async_rst_state", state_dbg, S_IDLE);
        check("async_rst_count", retired_count, 0);
        @(posedge clk); #1;
        do_reset();

        // randomized instruction mix
        for (int c = 0; c < 2500; c++) begin
            if (m_ph == S_TRAP) do_reset();
            if (m_ph == S_FETCH || m_ph == S_IDLE) pick_random();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
